// File: rtl/programmable_countdown_timer_if.sv
// Command/status bundle for the programmable countdown timer.
// The master issues commands and observes status; the timer is the slave.
interface programmable_countdown_timer_if #(
    parameter int WIDTH = 26
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             mode;
    logic             pulse;
    logic             done;
    logic             running;
    logic [WIDTH-1:0] count;

    modport master (
        output enable,
        output load,
        output load_value,
        output start,
        output mode,
        input  pulse,
        input  done,
        input  running,
        input  count
    );

    modport slave (
        input  enable,
        input  load,
        input  load_value,
        input  start,
        input  mode,
        output pulse,
        output done,
        output running,
        output count
    );
endinterface

// File: rtl/programmable_countdown_timer.sv
// Programmable down-counter with periodic and one-shot modes.
// Emits a registered one-cycle pulse each time a zero count is consumed.
module programmable_countdown_timer #(
    parameter int               WIDTH        = 26,
    parameter logic [WIDTH-1:0] DEFAULT_LOAD = WIDTH'(39_999_999),
    parameter bit               AUTO_START   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    programmable_countdown_timer_if.slave  tif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             pulse_q,  pulse_d;

    // Commands are prioritised load > start > counting; the pulse is only
    // ever raised by consuming a zero count while running and enabled.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        pulse_d  = 1'b0;

        if (tif.load) begin
            reload_d = tif.load_value;
            count_d  = tif.load_value;
            state_d  = IDLE;
        end else if (tif.start && (state_q != RUN)) begin
            count_d = reload_q;
            mode_d  = tif.mode;
            state_d = RUN;
        end else if ((state_q == RUN) && tif.enable) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                pulse_d = 1'b1;
                if (mode_q) begin
                    state_d = EXPIRED;
                end else begin
                    count_d = reload_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            count_q  <= DEFAULT_LOAD;
            reload_q <= DEFAULT_LOAD;
            mode_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            pulse_q  <= pulse_d;
        end
    end

    // Status is decoded from registered state only, so no input reaches
    // an output combinationally.
    assign tif.pulse   = pulse_q;
    assign tif.done    = (state_q == EXPIRED);
    assign tif.running = (state_q == RUN);
    assign tif.count   = count_q;

endmodule

// File: tb/tb_programmable_countdown_timer.sv
// Directed scenarios plus random stimulus for the countdown timer,
// checked cycle by cycle against a rule-level reference model.
module tb_programmable_countdown_timer;

    localparam int         W  = 8;
    localparam logic [7:0] DL = 8'd39;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_EXPIRED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    programmable_countdown_timer_if #(.WIDTH(W)) tif();

    programmable_countdown_timer #(
        .WIDTH        (W),
        .DEFAULT_LOAD (DL),
        .AUTO_START   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int   m_state;
    int   m_count;
    int   m_reload;
    bit   m_one_shot;
    bit   m_pulse;

    // Pulse bookkeeping on the DUT side
    int cycle;
    int dut_pulses;
    int first_pulse_cycle;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic void modelStep(input bit r, input bit en, input bit ld,
                                      input int lv, input bit st, input bit md);
        m_pulse = 1'b0;
        if (r) begin
            m_reload   = DL;
            m_count    = DL;
            m_one_shot = 1'b0;
            m_state    = M_RUN;
        end else if (ld) begin
            m_reload = lv;
            m_count  = lv;
            m_state  = M_IDLE;
        end else if (st && m_state != M_RUN) begin
            m_count    = m_reload;
            m_one_shot = md;
            m_state    = M_RUN;
        end else if (m_state == M_RUN && en) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                m_pulse = 1'b1;
                if (m_one_shot) m_state = M_EXPIRED;
                else            m_count = m_reload;
            end
        end
    endfunction

    function automatic void clearPulseLog();
        cycle             = 0;
        dut_pulses        = 0;
        first_pulse_cycle = -1;
    endfunction

    task automatic applyStimulus(input bit r, input bit en, input bit ld,
                                 input logic [7:0] lv, input bit st, input bit md);
        @(negedge clk);
        rst            = r;
        tif.enable     = en;
        tif.load       = ld;
        tif.load_value = lv;
        tif.start      = st;
        tif.mode       = md;
        @(posedge clk);
        modelStep(r, en, ld, int'(lv), st, md);
        #1;
        cycle++;
        if (tif.pulse === 1'b1) begin
            dut_pulses++;
            if (first_pulse_cycle < 0) first_pulse_cycle = cycle;
        end
        checkOutput("count",   32'(tif.count),   32'(m_count));
        checkOutput("pulse",   32'(tif.pulse),   32'(m_pulse));
        checkOutput("running", 32'(tif.running), 32'(m_state == M_RUN));
        checkOutput("done",    32'(tif.done),    32'(m_state == M_EXPIRED));
    endtask

    initial begin
        tif.enable     = 1'b0;
        tif.load       = 1'b0;
        tif.load_value = '0;
        tif.start      = 1'b0;
        tif.mode       = 1'b0;
        m_state = M_IDLE; m_count = 0; m_reload = 0; m_one_shot = 0; m_pulse = 0;
        clearPulseLog();

        // Reset held several cycles, then free-running periodic count
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("reset_count", 32'(tif.count), 32'(DL));
        clearPulseLog();
        for (int i = 0; i < 85; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("first_pulse_after_reset", 32'(first_pulse_cycle), 32'd40);
        checkOutput("pulses_in_85", 32'(dut_pulses), 32'd2);

        // Reset mid-count at 17 restarts the full period
        for (int i = 0; i < 100 && m_count != 17; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("reached_17", 32'(tif.count), 32'd17);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("count_after_midreset", 32'(tif.count), 32'd39);
        clearPulseLog();
        for (int i = 0; i < 45; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("pulse_after_midreset", 32'(first_pulse_cycle), 32'd40);

        // One-shot from a loaded value of 4
        applyStimulus(0, 1, 1, 8'd4, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 1);
        clearPulseLog();
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("oneshot_pulse_cycle", 32'(first_pulse_cycle), 32'd5);
        checkOutput("oneshot_pulse_total", 32'(dut_pulses), 32'd1);
        checkOutput("oneshot_done", 32'(tif.done), 32'd1);
        checkOutput("oneshot_count", 32'(tif.count), 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("oneshot_restart", 32'(tif.count), 32'd4);

        // Enable gap of 10 edges stretches the period to 50
        applyStimulus(0, 1, 1, 8'd39, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        clearPulseLog();
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("gap_interval", 32'(first_pulse_cycle), 32'd50);

        // Reload of zero in periodic mode pulses every enabled edge
        applyStimulus(0, 1, 1, 8'd0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        clearPulseLog();
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("zero_reload_pulses", 32'(dut_pulses), 32'd10);

        // Load and start together while running: load wins
        applyStimulus(0, 1, 1, 8'd9, 1, 0);
        checkOutput("load_wins_running", 32'(tif.running), 32'd0);
        checkOutput("load_wins_count", 32'(tif.count), 32'd9);
        checkOutput("load_wins_pulse", 32'(tif.pulse), 32'd0);

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 39) == 0),
                          8'($urandom_range(0, 12)),
                          ($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
